// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: data width, default FIFO depth and
// the byte/flag types used by the receive FIFO.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_W   = 8;
  localparam int unsigned RX_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uartByte_t;

  typedef struct packed {
    logic overflow;
    logic frameErr;
  } rxFlags_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x UART_DATA_W storage for the receive FIFO: one synchronous write
// port and an asynchronous read port so the head byte has no extra latency.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH  = RX_FIFO_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wrEn,
  input  logic [ADDR_W-1:0]      wrAddr,
  input  logic [UART_DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0]      rdAddr,
  output logic [UART_DATA_W-1:0] rdData
);

  uartByte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  always_comb begin
    rdData = mem[rdAddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the Uart8 receiver: captures one byte per
// rxDone rising edge, drops errored frames, presents bytes first-word-fall-through.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH  = RX_FIFO_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  logic [UART_DATA_W-1:0] rxByte,
  input  logic                   rdEn,
  output logic [UART_DATA_W-1:0] rdData,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   frameErr,
  input  logic                   clrFlags
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic            rxDonePrev;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W:0] countQ;
  rxFlags_t        flagsQ;

  logic            rxRise;
  logic            push;
  logic            pop;
  logic            wrEn;
  logic            ovfSet;
  logic            ferrSet;
  logic [ADDR_W:0] countNext;
  rxFlags_t        flagsNext;
  uartByte_t       headByte;

  uart_rx_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk   (clk),
    .wrEn  (wrEn),
    .wrAddr(wrPtr),
    .wrData(rxByte),
    .rdAddr(rdPtr),
    .rdData(headByte)
  );

  always_comb begin
    empty  = (countQ == '0);
    full   = (countQ == DEPTH_CNT);
    rxRise = rxDone & ~rxDonePrev;
    push   = rxRise & ~rxErr;
    pop    = rdEn & ~empty;
    // When full, a concurrent pop frees the slot being written this cycle;
    // the async read still returns the old head before the write lands.
    wrEn    = push & (~full | pop);
    ovfSet  = push & full & ~pop;
    ferrSet = rxRise & rxErr;

    countNext = countQ;
    if (wrEn && !pop) begin
      countNext = countQ + CNT_ONE;
    end else if (!wrEn && pop) begin
      countNext = countQ - CNT_ONE;
    end

    // A set event in the same cycle as clrFlags takes priority.
    flagsNext = flagsQ;
    if (clrFlags) begin
      flagsNext = '0;
    end
    if (ovfSet) begin
      flagsNext.overflow = 1'b1;
    end
    if (ferrSet) begin
      flagsNext.frameErr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // History starts high so a level already present at release is not a frame.
      rxDonePrev <= 1'b1;
      wrPtr      <= '0;
      rdPtr      <= '0;
      countQ     <= '0;
      flagsQ     <= '0;
    end else begin
      rxDonePrev <= rxDone;
      if (wrEn) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      countQ <= countNext;
      flagsQ <= flagsNext;
    end
  end

  always_comb begin
    count    = countQ;
    overflow = flagsQ.overflow;
    frameErr = flagsQ.frameErr;
    rdData   = empty ? '0 : headByte;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxDone = 1'b0;
  logic       rxErr = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic       rdEn = 1'b0;
  logic       clrFlags = 1'b0;
  logic [7:0] rdData;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       frameErr;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  uart_rx_fifo #(
    .DEPTH(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rxDone  (rxDone),
    .rxErr   (rxErr),
    .rxByte  (rxByte),
    .rdEn    (rdEn),
    .rdData  (rdData),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overflow(overflow),
    .frameErr(frameErr),
    .clrFlags(clrFlags)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic err, input int hold);
    rxByte = b;
    rxErr  = err;
    rxDone = 1'b1;
    repeat (hold) tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b exp=1", empty); end
    vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got=%b exp=0", full); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    vecs++; if (frameErr !== 1'b0) begin errs++; $display("FAIL reset_frameErr got=%b exp=0", frameErr); end
    vecs++; if (rdData !== 8'h00) begin errs++; $display("FAIL reset_rdData got=%h exp=00", rdData); end
  endtask

  task automatic test_single_byte();
    rxByte = 8'b01010110;
    rxDone = 1'b1;
    tick();
    vecs++; if (count !== 5'd1) begin errs++; $display("FAIL single_count got=%0d exp=1", count); end
    vecs++; if (rdData !== 8'h56) begin errs++; $display("FAIL single_rdData got=%h exp=56", rdData); end
    vecs++; if (empty !== 1'b0) begin errs++; $display("FAIL single_empty got=%b exp=0", empty); end
    repeat (2) tick();
    vecs++; if (count !== 5'd1) begin errs++; $display("FAIL single_level_count got=%0d exp=1", count); end
    rxDone = 1'b0;
    tick();
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL single_pop_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) sendFrame(8'(i), 1'b0, 1);
    vecs++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full got=%b exp=1", full); end
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fill_count got=%0d exp=16", count); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fill_no_overflow got=%b exp=0", overflow); end
    sendFrame(8'hAA, 1'b0, 2);
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fill_ovf_count got=%0d exp=16", count); end
    for (int i = 0; i < 16; i++) begin
      vecs++; if (rdData !== 8'(i)) begin errs++; $display("FAIL fill_pop%0d got=%h exp=%h", i, rdData, 8'(i)); end
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
    end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL fill_drained_empty got=%b exp=1", empty); end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL pop_empty_count got=%0d exp=0", count); end
    vecs++; if (frameErr !== 1'b0) begin errs++; $display("FAIL pop_empty_frameErr got=%b exp=0", frameErr); end
    clrFlags = 1'b1;
    tick();
    clrFlags = 1'b0;
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_error_frame();
    sendFrame(8'h56, 1'b1, 2);
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL err_count got=%0d exp=0", count); end
    vecs++; if (frameErr !== 1'b1) begin errs++; $display("FAIL err_frameErr got=%b exp=1", frameErr); end
    clrFlags = 1'b1;
    tick();
    clrFlags = 1'b0;
    vecs++; if (frameErr !== 1'b0) begin errs++; $display("FAIL err_clr got=%b exp=0", frameErr); end
    // Error edge coincident with clrFlags: set wins.
    rxByte = 8'h12;
    rxErr = 1'b1;
    rxDone = 1'b1;
    clrFlags = 1'b1;
    tick();
    clrFlags = 1'b0;
    rxDone = 1'b0;
    rxErr = 1'b0;
    vecs++; if (frameErr !== 1'b1) begin errs++; $display("FAIL err_set_wins got=%b exp=1", frameErr); end
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL err_set_wins_count got=%0d exp=0", count); end
    clrFlags = 1'b1;
    tick();
    clrFlags = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) sendFrame(8'h10 + 8'(i), 1'b0, 1);
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fpp_pre_count got=%0d exp=16", count); end
    rxByte = 8'h77;
    rxDone = 1'b1;
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    rxDone = 1'b0;
    vecs++; if (count !== 5'd16) begin errs++; $display("FAIL fpp_count got=%0d exp=16", count); end
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    vecs++; if (rdData !== 8'h11) begin errs++; $display("FAIL fpp_head got=%h exp=11", rdData); end
    tick();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'h77 : 8'h11 + 8'(i);
      vecs++; if (rdData !== exp) begin errs++; $display("FAIL fpp_pop%0d got=%h exp=%h", i, rdData, exp); end
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
    end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL fpp_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_push_pop();
    rxByte = 8'hC3;
    rxDone = 1'b1;
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    rxDone = 1'b0;
    vecs++; if (count !== 5'd1) begin errs++; $display("FAIL epp_count got=%0d exp=1", count); end
    vecs++; if (rdData !== 8'hC3) begin errs++; $display("FAIL epp_rdData got=%h exp=c3", rdData); end
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL epp_drain got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'h40 + 8'(i);
      sendFrame(d, 1'b0, 1);
      vecs++; if (count !== 5'd1) begin errs++; $display("FAIL wrap%0d_count got=%0d exp=1", i, count); end
      vecs++; if (rdData !== d) begin errs++; $display("FAIL wrap%0d_data got=%h exp=%h", i, rdData, d); end
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      vecs++; if (count !== 5'd0) begin errs++; $display("FAIL wrap%0d_pop got=%0d exp=0", i, count); end
    end
  endtask

  task automatic test_back_to_back_reset();
    for (int i = 0; i < 5; i++) sendFrame(8'hE0 + 8'(i), 1'b0, 1);
    vecs++; if (count !== 5'd5) begin errs++; $display("FAIL rst_pre_count got=%0d exp=5", count); end
    rxByte = 8'h99;
    rxDone = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL rst_count got=%0d exp=0", count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty got=%b exp=1", empty); end
    rxDone = 1'b0;
    tick();
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL rst_fall_count got=%0d exp=0", count); end
    rxByte = 8'h3C;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    vecs++; if (count !== 5'd1) begin errs++; $display("FAIL rst_fresh_count got=%0d exp=1", count); end
    vecs++; if (rdData !== 8'h3C) begin errs++; $display("FAIL rst_fresh_data got=%h exp=3c", rdData); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill();
    test_error_frame();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
